pipeline_hazard_controller: RTL
===============================

// Module: pipeline_hazard_controller
// PURPOSE
//  Central sequencer for the 5-stage RISC-V pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Drives per-register enables and flushes for three events: data-memory wait states, load-use hazards and EX-resolved redirects.
//  Guards the dmem handshake with a timeout and counts stall cycles for performance monitoring.
//  Sits beside the datapath; all pipeline registers take their enable/flush from this block.
// PARAMETERS
//  MEM_TIMEOUT  16  cycles MEM_WAIT may last before ERROR (>=2)
//  STALL_CNT_W  16  width of saturating stall_count
// PORTS
//  clock          in   1   rising-edge clock
//  reset          in   1   asynchronous, active-low reset
//  id_rs1/id_rs2  in   5   source regs of the instruction in ID
//  id_uses_rs1/2  in   1   ID instruction actually reads rs1 / rs2
//  ex_is_load     in   1   instruction in EX is a load
//  ex_rd          in   5   destination reg of the instruction in EX
//  ex_redirect    in   1   taken branch/jump resolved in EX
//  mem_access     in   1   instruction in MEM needs dmem (load or store)
//  dmem_ack       in   1   dmem completes the access this cycle
//  dmem_req       out  1   dmem request
//  pc_en          out  1   PC update enable
//  if_id_en/id_ex_en/ex_mem_en/mem_wb_en  out 1  register load enables
//  if_id_flush/id_ex_flush  out 1  register loads all-zero (bubble) when its enable is 1
//  mem_wb_bubble  out  1   MEM/WB loads zero (writeback=0) instead of MEM results
//  timeout_err    out  1   sticky dmem timeout flag
//  stall_count    out  STALL_CNT_W  saturating count of cycles with pc_en==0
// BEHAVIOUR
//  State: RUN, MEM_WAIT, ERROR; timer[$clog2(MEM_TIMEOUT)] and stall_count are registered; all other outputs are combinational from state + inputs (zero-cycle decision latency).
//  Reset (reset==0): state=RUN, timer=0, stall_count=0, timeout_err=0; while reset is low, dmem_req=0, all enables=0, all flush/bubble=0.
//  Default (RUN, no event): all enables=1, flushes=0, dmem_req=mem_access.
//  Priority: ERROR > mem stall > redirect > load-use > default.
//  RUN, mem_access & dmem_ack: zero-wait access, default outputs, stay RUN.
//  RUN, mem_access & !dmem_ack: pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_en=1, mem_wb_bubble=1; next=MEM_WAIT, timer=1.
//  MEM_WAIT: dmem_req=1; same freeze as above each cycle; timer++.
//   dmem_ack -> all enables=1, mem_wb_bubble=0 (results captured), redirect/load-use evaluated normally this cycle; next=RUN, timer=0.
//   !dmem_ack & timer==MEM_TIMEOUT-1 -> next=ERROR.
//  ERROR: all enables=0, dmem_req=0, timeout_err=1; left only by reset.
//  Redirect (ex_redirect, no mem stall): pc_en=1, if_id_flush=1, id_ex_flush=1, all enables=1; overrides load-use.
//  Redirect during mem stall: ignored; EX is frozen, so it is re-presented and acted on in the release cycle.
//  Load-use: ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
//   -> pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1, ex_mem_en=1, mem_wb_en=1: exactly one bubble.
//  stall_count: +1 on every cycle with pc_en==0 in RUN/MEM_WAIT; holds at all-ones; not incremented in ERROR.
//  Reset mid-MEM_WAIT: immediate return to RUN, dmem_req drops asynchronously.
// TESTING
//  Load x5 in EX, ID reads rs1=x5 -> 1 cycle pc_en=0, id_ex_flush=1; next cycle default; stall_count=1.
//  Load x0 in EX, ID reads rs1=x0 -> no stall, stall_count=0.
//  mem_access with ack after 3 cycles -> 3 cycles frozen with mem_wb_bubble=1; release cycle all en=1; stall_count=3.
//  ex_redirect and load-use in the same cycle -> if_id_flush=id_ex_flush=1, pc_en=1, no stall.
//  mem_access, ack never arrives, MEM_TIMEOUT=4 -> ERROR after 4 cycles, timeout_err=1 sticky, dmem_req=0.
//  Reset low during MEM_WAIT -> dmem_req=0 and enables=0 immediately; after reset high: RUN, counters 0.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline hazard controller bundle.
// Groups the hazard-detection inputs, the dmem handshake and the pipeline
// register controls that pass between the datapath and the hazard controller.
//   master : hazard controller side (drives enables, flushes, dmem_req, status)
//   slave  : datapath side (drives hazard inputs and dmem_ack)
// Signals:
//   id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 : ID-stage source operands
//   ex_is_load, ex_rd, ex_redirect          : EX-stage load / redirect info
//   mem_access, dmem_ack, dmem_req          : dmem handshake
//   pc_en, *_en, *_flush, mem_wb_bubble     : pipeline register controls
//   timeout_err, stall_count                : status / performance counter
interface pipeline_hazard_controller_if #(
    parameter int unsigned STALL_CNT_W = 16
);
    logic [4:0]             id_rs1;
    logic [4:0]             id_rs2;
    logic                   id_uses_rs1;
    logic                   id_uses_rs2;
    logic                   ex_is_load;
    logic [4:0]             ex_rd;
    logic                   ex_redirect;
    logic                   mem_access;
    logic                   dmem_ack;
    logic                   dmem_req;
    logic                   pc_en;
    logic                   if_id_en;
    logic                   id_ex_en;
    logic                   ex_mem_en;
    logic                   mem_wb_en;
    logic                   if_id_flush;
    logic                   id_ex_flush;
    logic                   mem_wb_bubble;
    logic                   timeout_err;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_is_load, ex_rd, ex_redirect, mem_access, dmem_ack,
        output dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, mem_wb_bubble, timeout_err, stall_count
    );

    modport slave (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_is_load, ex_rd, ex_redirect, mem_access, dmem_ack,
        input  dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, mem_wb_bubble, timeout_err, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Central sequencer for the 5-stage pipeline registers. Decides per-register
// enables/flushes for dmem wait states, load-use hazards and EX redirects,
// guards the dmem handshake with a timeout, and counts stall cycles.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : pipeline_hazard_controller_if.master (hazard inputs, dmem
//           handshake, register controls, timeout_err, stall_count)
// Decisions are combinational from state + inputs; only the state, the wait
// timer and stall_count are registered.
module pipeline_hazard_controller #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned STALL_CNT_W = 16
) (
    input logic                          clock,
    input logic                          reset,
    pipeline_hazard_controller_if.master bus
);
    localparam int unsigned TIMER_W = $clog2(MEM_TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERROR    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [STALL_CNT_W-1:0] stall_q;

    logic load_use;
    logic freeze, advance;
    logic dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, mem_wb_bubble, timeout_err;

    assign load_use = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                      ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        freeze        = 1'b0;
        advance       = 1'b0;
        dmem_req      = 1'b0;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        timeout_err   = 1'b0;

        case (state_q)
            S_RUN: begin
                dmem_req = bus.mem_access;
                timer_d  = '0;
                if (bus.mem_access && !bus.dmem_ack) begin
                    freeze  = 1'b1;
                    state_d = S_MEM_WAIT;
                    timer_d = TIMER_W'(1);
                end else begin
                    advance = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                dmem_req = 1'b1;
                if (bus.dmem_ack) begin
                    advance = 1'b1;
                    state_d = S_RUN;
                    timer_d = '0;
                end else begin
                    freeze  = 1'b1;
                    timer_d = timer_q + TIMER_W'(1);
                    if (timer_q == TIMER_LAST) begin
                        state_d = S_ERROR;
                        timer_d = '0;
                    end
                end
            end
            S_ERROR: begin
                timeout_err = 1'b1;
            end
            default: begin
                state_d = S_RUN;
                timer_d = '0;
            end
        endcase

        // Mem stall: only MEM/WB moves, and it captures a bubble.
        if (freeze) begin
            mem_wb_en     = 1'b1;
            mem_wb_bubble = 1'b1;
        end

        // Normal advance; a redirect squashes IF/ID and ID/EX, which also
        // removes the consumer of any load-use hazard, so it wins.
        if (advance) begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (bus.ex_redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_RUN;
            timer_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if ((state_q != S_ERROR) && !pc_en && (stall_q != '1)) begin
                stall_q <= stall_q + STALL_CNT_W'(1);
            end
        end
    end

    // Outputs are gated by reset so everything drops asynchronously.
    assign bus.dmem_req      = reset & dmem_req;
    assign bus.pc_en         = reset & pc_en;
    assign bus.if_id_en      = reset & if_id_en;
    assign bus.id_ex_en      = reset & id_ex_en;
    assign bus.ex_mem_en     = reset & ex_mem_en;
    assign bus.mem_wb_en     = reset & mem_wb_en;
    assign bus.if_id_flush   = reset & if_id_flush;
    assign bus.id_ex_flush   = reset & id_ex_flush;
    assign bus.mem_wb_bubble = reset & mem_wb_bubble;
    assign bus.timeout_err   = reset & timeout_err;
    assign bus.stall_count   = stall_q;
endmodule
